// File: rtl/cpu6_pipe_reg_pkg.sv
// Shared definitions for the cpu6 elastic pipeline register.
package cpu6_pipe_reg_pkg;

   localparam int unsigned CPU6_DW_DEF    = 32;
   localparam int unsigned CPU6_DEPTH_DEF = 2;

   // What the occupancy counter does on the coming edge.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2,
      CNT_CLR  = 2'd3
   } cnt_op_e;

   // Width needed to hold an occupancy of 0..depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/cpu6_pipe_reg_if.sv
// Upstream and downstream valid/ready handshake of the pipeline register.
// The slave view belongs to the register chain, the master view to the
// logic that surrounds it.
interface cpu6_pipe_reg_if
   import cpu6_pipe_reg_pkg::*;
#(
   parameter int DW = CPU6_DW_DEF
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/cpu6_pipe_stage.sv
// One stage of the elastic chain: a valid bit and a payload word, both
// load-enable flops with asynchronous active-low reset.
module cpu6_pipe_stage #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          src,
   input  logic          adv,
   input  logic [DW-1:0] src_data,
   output logic          v,
   output logic [DW-1:0] d
);

   // Valid bit: filled from behind, emptied when moving on, cleared by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= 1'b0;
      end else if (flush) begin
         v <= 1'b0;
      end else begin
         v <= src | (v & ~adv);
      end
   end

   // Payload: loads only when a new item arrives; flush leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d <= '0;
      end else if (src && !flush) begin
         d <= src_data;
      end
   end

endmodule

// File: rtl/cpu6_pipe_reg.sv
// Elastic pipeline register: DEPTH stages with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
module cpu6_pipe_reg
   import cpu6_pipe_reg_pkg::*;
#(
   parameter  int DW    = CPU6_DW_DEF,
   parameter  int DEPTH = CPU6_DEPTH_DEF,
   localparam int CW    = cnt_width(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   cpu6_pipe_reg_if.slave      bus,
   output logic [CW-1:0]       count
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src;
   logic [DW-1:0]    d        [DEPTH];
   logic [DW-1:0]    src_data [DEPTH];
   logic             in_ready_w;
   logic             acc;
   logic             pop;
   cnt_op_e          cnt_op;
   logic [CW-1:0]    count_q;

   // Advance terms, from the output side backward. A valid stage moves when
   // any stage ahead of it is empty, or when the whole run ahead is full and
   // the head is leaving; written this way the chain has no self-feedback.
   always_comb begin : adv_chain
      logic all_full;
      all_full = 1'b1;
      adv      = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         adv[i]   = v[i] & (~all_full | bus.out_ready);
         all_full = all_full & v[i];
      end
   end

   assign in_ready_w = ~flush & (~v[0] | adv[0]);
   assign acc        = bus.in_valid & in_ready_w;
   assign pop        = v[DEPTH-1] & bus.out_ready;

   // Each stage is fed by the stage behind it; stage 0 by the input port.
   always_comb begin
      src         = '0;
      src[0]      = acc;
      src_data[0] = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src[i]      = adv[i-1];
         src_data[i] = d[i-1];
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      cpu6_pipe_stage #(
         .DW (DW)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .src      (src[gi]),
         .adv      (adv[gi]),
         .src_data (src_data[gi]),
         .v        (v[gi]),
         .d        (d[gi])
      );
   end

   // Occupancy update: push and pop together cancel; flush wins over both.
   always_comb begin
      cnt_op = CNT_HOLD;
      if (flush) begin
         cnt_op = CNT_CLR;
      end else if (acc && !pop) begin
         cnt_op = CNT_INC;
      end else if (pop && !acc) begin
         cnt_op = CNT_DEC;
      end
   end

   // Occupancy register, kept in step with the population of v[].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         case (cnt_op)
            CNT_INC:  count_q <= count_q + CW'(1);
            CNT_DEC:  count_q <= count_q - CW'(1);
            CNT_CLR:  count_q <= '0;
            default:  count_q <= count_q;
         endcase
      end
   end

   assign count         = count_q;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = v[DEPTH-1];
   assign bus.out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_cpu6_pipe_reg.sv
// Bench for cpu6_pipe_reg: three instances (DEPTH 3, 4 and 1, DW 8) checked
// every cycle against an item-position model, plus literal expectations.
module tb_cpu6_pipe_reg;

   localparam int NI = 3;
   localparam int DEPS [NI] = '{3, 4, 1};

   logic       clk;
   logic       rstn [NI];
   logic       fl   [NI];
   logic       iv   [NI];
   logic [7:0] id   [NI];
   logic       ordy [NI];

   logic        o_ir  [NI];
   logic        o_ov  [NI];
   logic [7:0]  o_od  [NI];
   logic [31:0] o_cnt [NI];

   int checks = 0;
   int errors = 0;

   // Model: per instance, the items held, oldest first, with their stage index.
   logic [7:0] md [NI][4];
   int         mp [NI][4];
   int         mn [NI];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DEP = DEPS[g];
      cpu6_pipe_reg_if #(.DW(8)) bus ();
      logic [$clog2(DEP+1)-1:0] cnt;

      assign bus.in_valid  = iv[g];
      assign bus.in_data   = id[g];
      assign bus.out_ready = ordy[g];
      assign o_ir[g]  = bus.in_ready;
      assign o_ov[g]  = bus.out_valid;
      assign o_od[g]  = bus.out_data;
      assign o_cnt[g] = 32'(cnt);

      cpu6_pipe_reg #(.DW(8), .DEPTH(DEP)) u_dut (
         .clk   (clk),
         .rst_n (rstn[g]),
         .flush (fl[g]),
         .bus   (bus),
         .count (cnt)
      );
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_out_valid(input int g);
      return (mn[g] > 0) && (mp[g][0] == DEPS[g] - 1);
   endfunction

   function automatic bit m_in_ready(input int g);
      return !fl[g] && ((mn[g] < DEPS[g]) || ordy[g]);
   endfunction

   // One clock edge for instance g: pop the head, close gaps, then push.
   task automatic model_step(input int g);
      bit pop, acc;
      int lim, np;
      pop = m_out_valid(g) && ordy[g];
      acc = iv[g] && m_in_ready(g);
      if (pop) begin
         for (int k = 1; k < mn[g]; k++) begin
            md[g][k-1] = md[g][k];
            mp[g][k-1] = mp[g][k];
         end
         mn[g]--;
      end
      if (fl[g]) begin
         mn[g] = 0;
      end else begin
         lim = DEPS[g] - 1;
         for (int k = 0; k < mn[g]; k++) begin
            np = (mp[g][k] + 1 < lim) ? mp[g][k] + 1 : lim;
            mp[g][k] = np;
            lim = np - 1;
         end
         if (acc) begin
            md[g][mn[g]] = id[g];
            mp[g][mn[g]] = 0;
            mn[g]++;
         end
      end
   endtask

   initial for (int g = 0; g < NI; g++) mn[g] = 0;

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (!rstn[g]) mn[g] = 0;
         else model_step(g);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (rstn[g]) begin
            chk($sformatf("g%0d in_ready", g), int'(o_ir[g]), int'(m_in_ready(g)));
            chk($sformatf("g%0d out_valid", g), int'(o_ov[g]), int'(m_out_valid(g)));
            chk($sformatf("g%0d count", g), int'(o_cnt[g]), mn[g]);
            if (m_out_valid(g))
               chk($sformatf("g%0d out_data", g), int'(o_od[g]), int'(md[g][0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc_seen [NI];
      for (int g = 0; g < NI; g++) begin
         rstn[g] = 1'b0; fl[g] = 1'b0; iv[g] = 1'b0; id[g] = 8'h00; ordy[g] = 1'b0;
      end
      #12;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("g%0d reset out_valid", g), int'(o_ov[g]), 0);
         chk($sformatf("g%0d reset out_data", g), int'(o_od[g]), 0);
         chk($sformatf("g%0d reset count", g), int'(o_cnt[g]), 0);
         chk($sformatf("g%0d reset in_ready", g), int'(o_ir[g]), 1);
      end
      @(posedge clk); #2;
      for (int g = 0; g < NI; g++) rstn[g] = 1'b1;
      tick();

      // Streaming, DEPTH=3
      ordy[0] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         iv[0] = 1'b1; id[0] = 8'(i);
         tick();
         if (i >= 3) begin
            chk("stream out_data", int'(o_od[0]), i - 2);
            chk("stream count", int'(o_cnt[0]), 3);
         end
      end
      iv[0] = 1'b0;
      repeat (4) tick();
      ordy[0] = 1'b0;

      // Backpressure, DEPTH=3
      iv[0] = 1'b1; id[0] = 8'hA1; tick();
      id[0] = 8'hA2; tick();
      id[0] = 8'hA3; tick();
      id[0] = 8'hA4;
      #1;
      chk("bp in_ready full", int'(o_ir[0]), 0);
      chk("bp count full", int'(o_cnt[0]), 3);
      tick(); tick();
      chk("bp held in_ready", int'(o_ir[0]), 0);
      ordy[0] = 1'b1;
      #1;
      chk("bp in_ready pop", int'(o_ir[0]), 1);
      chk("bp head", int'(o_od[0]), 8'hA1);
      tick();
      iv[0] = 1'b0; ordy[0] = 1'b0;
      #1;
      chk("bp count after", int'(o_cnt[0]), 3);
      chk("bp next head", int'(o_od[0]), 8'hA2);
      ordy[0] = 1'b1;
      repeat (4) tick();
      ordy[0] = 1'b0;

      // Bubble collapse, DEPTH=4
      iv[1] = 1'b1; id[1] = 8'h55; tick();
      iv[1] = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("bubble count", int'(o_cnt[1]), 1);
         chk("bubble out_valid", int'(o_ov[1]), (i == 3) ? 1 : 0);
      end
      chk("bubble head", int'(o_od[1]), 8'h55);
      for (int i = 0; i < 3; i++) begin
         iv[1] = 1'b1; id[1] = 8'(8'h61 + i); tick();
      end
      iv[1] = 1'b0;
      #1;
      chk("bubble full count", int'(o_cnt[1]), 4);
      chk("bubble full in_ready", int'(o_ir[1]), 0);
      ordy[1] = 1'b1;
      repeat (5) tick();
      ordy[1] = 1'b0;

      // Flush, DEPTH=3 with two items
      iv[0] = 1'b1; id[0] = 8'hB1; tick();
      id[0] = 8'hB2; tick();
      iv[0] = 1'b0; tick();
      chk("flush pre count", int'(o_cnt[0]), 2);
      fl[0] = 1'b1; iv[0] = 1'b1; id[0] = 8'hCC; ordy[0] = 1'b1;
      #1;
      chk("flush in_ready", int'(o_ir[0]), 0);
      chk("flush out_valid", int'(o_ov[0]), 1);
      chk("flush head", int'(o_od[0]), 8'hB1);
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0;
      chk("flush post count", int'(o_cnt[0]), 0);
      chk("flush post out_valid", int'(o_ov[0]), 0);
      repeat (3) tick();
      ordy[0] = 1'b0;

      // Asynchronous reset mid-operation, DEPTH=3
      iv[0] = 1'b1; id[0] = 8'hC1; tick();
      id[0] = 8'hC2; tick();
      iv[0] = 1'b0;
      chk("rst pre count", int'(o_cnt[0]), 2);
      tick();
      chk("rst pre out_valid", int'(o_ov[0]), 1);
      #3;
      rstn[0] = 1'b0;
      #1;
      chk("rst out_valid", int'(o_ov[0]), 0);
      chk("rst out_data", int'(o_od[0]), 0);
      chk("rst count", int'(o_cnt[0]), 0);
      @(posedge clk); #2;
      rstn[0] = 1'b1;
      #1;
      chk("rst release in_ready", int'(o_ir[0]), 1);
      tick();

      // DEPTH=1 full throughput
      ordy[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         iv[2] = 1'b1; id[2] = 8'(8'h70 + i); tick();
         chk("d1 out_data", int'(o_od[2]), 8'h70 + i);
         chk("d1 count", int'(o_cnt[2]), 1);
      end
      iv[2] = 1'b0;
      tick();
      ordy[2] = 1'b0;

      // Randomized traffic on all instances; sources hold until accepted.
      for (int g = 0; g < NI; g++) acc_seen[g] = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         for (int g = 0; g < NI; g++) begin
            if (!(iv[g] && !acc_seen[g])) begin
               iv[g] = ($urandom_range(0, 3) != 0);
               id[g] = 8'($urandom);
            end
            ordy[g] = ($urandom_range(0, 9) < 6);
            fl[g]   = ($urandom_range(0, 29) == 0);
         end
         @(negedge clk);
         for (int g = 0; g < NI; g++) acc_seen[g] = iv[g] && o_ir[g];
         tick();
      end
      for (int g = 0; g < NI; g++) begin
         iv[g] = 1'b0; fl[g] = 1'b0; ordy[g] = 1'b1;
      end
      repeat (6) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
